// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one operand bit per clock.
// A start/done handshake requests a conversion and presents the packed BCD result.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3,
    parameter int BCD_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_WIDTH-1:0]          bin,
    output logic                          busy,
    output logic                          done,
    output logic [DIGITS*BCD_WIDTH-1:0]   bcd,
    output logic                          overflow
);

    localparam int DW = DIGITS * BCD_WIDTH;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] shreg;
    logic [DW-1:0]        scratch;
    logic [DW-1:0]        adj;
    logic [DW-1:0]        shifted;
    logic                 ovf_acc;
    logic                 spill;
    logic [CW-1:0]        count;

    // Add-3 correction on every digit, then shift one operand bit into digit 0.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[i*BCD_WIDTH +: BCD_WIDTH] >= BCD_WIDTH'(5))
                adj[i*BCD_WIDTH +: BCD_WIDTH] = scratch[i*BCD_WIDTH +: BCD_WIDTH] + BCD_WIDTH'(3);
        end
        shifted = {adj[DW-2:0], shreg[BIN_WIDTH-1]};
        spill   = adj[DW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            count    <= '0;
            shreg    <= '0;
            scratch  <= '0;
            ovf_acc  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        ovf_acc <= 1'b0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end else begin
                        state <= IDLE;
                    end
                end
                CONVERT: begin
                    scratch <= shifted;
                    shreg   <= shreg << 1;
                    ovf_acc <= ovf_acc | spill;
                    // The final shift result goes straight to the outputs on the same edge.
                    if (count == LAST) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bcd      <= shifted;
                        overflow <= ovf_acc | spill;
                        state    <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
